// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one full-adder cell LSB-first, one bit per clock.
// {cout, sum} = a + b + cin is registered on the last RUN edge, followed by a one-cycle done pulse.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic [1:0]       dbg_state
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q, sr_q, sum_q;
   logic [WIDTH-1:0] sa_d, sb_d, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, cout_q, busy_q, done_q;
   logic             fa_sum;

   // The single full-adder cell and the next values of the shifting datapath.
   always_comb begin
      fa_sum        = sa_q[0] ^ sb_q[0] ^ c_q;
      c_d           = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
      sa_d          = sa_q >> 1;
      sb_d          = sb_q >> 1;
      sr_d          = sr_q >> 1;
      sr_d[WIDTH-1] = fa_sum;
      cnt_d         = cnt_q + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         sa_q    <= '0;
         sb_q    <= '0;
         sr_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  c_q     <= cin;
                  cnt_q   <= '0;
                  sr_q    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               sa_q  <= sa_d;
               sb_q  <= sb_d;
               sr_q  <= sr_d;
               c_q   <= c_d;
               cnt_q <= cnt_d;
               // Final bit: publish the result straight from the adder cell.
               if (cnt_q == LAST) begin
                  sum_q   <= sr_d;
                  cout_q  <= c_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign dbg_state = state_q;
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller. Accepts two WIDTH-bit operands and a carry-in on a start pulse, then sequences a single 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) LSB-first, one bit per clock. It sits between a requesting master and the 1-bit full-adder datapath, so wide additions reuse one adder cell instead of a WIDTH-bit ripple chain.

## Interface

- WIDTH, default 8, operand/result width in bits; legal range 1..32.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on accepted start.
- b  in  WIDTH  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while bits are being processed (state RUN).
- done  out  1  one-cycle pulse: sum/cout just updated.
- sum  out  WIDTH  registered result; held between operations.
- cout  out  1  registered final carry; held between operations.

## Operation

- Internal state: shift registers sa, sb (WIDTH), result shift register sr (WIDTH), carry register c, bit counter cnt (0..WIDTH-1), FSM {IDLE, RUN, DONE}.
- IDLE: busy=0, done=0. If start=1: sa<=a, sb<=b, c<=cin, cnt<=0, sr<=0, go RUN. Otherwise stay.
- RUN: busy=1. Each cycle the full-adder cell sees (sa[0], sb[0], c). On the edge: sr<={fa_sum, sr[WIDTH-1:1]}, c<=fa_carry, sa and sb shift right by 1, cnt<=cnt+1.
  - If cnt==WIDTH-1 on that edge: sum<={fa_sum, sr[WIDTH-1:1]}, cout<=fa_carry, go DONE.
- DONE: done=1, busy=0 for exactly one cycle, then unconditionally go IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored; a/b/cin changes after capture have no effect.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- sum/cout change only on the final RUN edge; they hold the last result otherwise, including through IDLE and a new RUN.
- WIDTH=1: RUN lasts exactly one cycle.

## Timing

- Reset (rst=1 on an edge): state<=IDLE, busy=0, done=0, sum=0, cout=0, cnt=0, c=0. rst has priority over start and all other activity.
- Reset mid-RUN aborts: no done pulse, and sum/cout are cleared to 0.
- Start accepted at edge E0. busy=1 for the cycles after E0 through EW, where EW is the WIDTH-th edge after E0.
- After EW: busy=0, done=1, sum/cout valid. done drops after edge EW+1.
- Latency is start-accept to done = WIDTH+1 cycles.
- With start held high, back-to-back operations are accepted every WIDTH+2 cycles (next accept at edge EW+2).
- busy and done are never high together. Both are pure functions of state, driven from registers.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse -> busy=1 for 8 cycles, done one cycle later with sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start pulses plus operand changes (a=0x11, b=0x22) during RUN and during DONE of a 0x5A+0x3C op -> ignored; result still 0x96/0. Exactly one done pulse.
- Reset asserted on the 4th RUN cycle of 0x5A+0x3C -> next cycle busy=0, done=0, sum=0x00, cout=0, and no done pulse follows. A subsequent start with 0x01+0x02 gives 0x03.
- start held high continuously with a=0x80, b=0x80, cin=0 -> done pulses every 10 cycles, each with sum=0x00, cout=1. sum stays stable between pulses.
- WIDTH=1 build: a=1, b=1, cin=1 -> busy for 1 cycle, then done with sum=1, cout=1.
